// File: rtl/sr_pkg.sv
// Shared constants for the shift-register sequencer and the 8-bit universal shift register.
//   MODE_*  : 2-bit {s1,s0} register mode codes
//   state_e : sequencer FSM states
package sr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/eightbitsr.sv
// 8-bit universal shift register driven by sr_shift_ctrl.
// Ports:
//   clk                rising-edge clock
//   s1, s0             mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load
//   parallel_in        word loaded in mode 11
//   shift_left_input   bit entering at bit 0 on a left shift
//   shift_right_input  bit entering at bit 7 on a right shift
//   out                register contents
// Contents are intentionally not reset; the controller keeps the register in HOLD instead.
module eightbitsr
  import sr_pkg::*;
(
  input  logic       clk,
  input  logic       s1,
  input  logic       s0,
  input  logic [7:0] parallel_in,
  input  logic       shift_left_input,
  input  logic       shift_right_input,
  output logic [7:0] out
);

  logic [7:0] out_q, out_d;

  always_comb begin
    out_d = out_q;
    case ({s1, s0})
      MODE_SHR:  out_d = {shift_right_input, out_q[7:1]};
      MODE_SHL:  out_d = {out_q[6:0], shift_left_input};
      MODE_LOAD: out_d = parallel_in;
      default:   out_d = out_q;
    endcase
  end

  always_ff @(posedge clk) begin
    out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: rtl/sr_shift_ctrl.sv
// Sequencer for the universal shift register: accepts a parallel word over valid/ready, loads it
// into the register, then streams WIDTH bits out serially (MSB- or LSB-first) honouring sink
// back-pressure, and pulses done after the last bit.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready/in_data        word handshake from the producer
//   in_msb_first                     1: shift left, MSB first; 0: shift right, LSB first
//   s1, s0                           register mode (00 hold, 01 shr, 10 shl, 11 load)
//   parallel_in                      latched word for the register's parallel input
//   shift_left_input/right_input     fill bit for the register while shifting
//   sr_q                             register contents
//   ser_out/ser_valid/ser_ready      serial bit handshake to the sink
//   done                             one-cycle pulse after the last bit transfers
module sr_shift_ctrl
  import sr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter logic        FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  output logic             s1,
  output logic             s0,
  output logic [WIDTH-1:0] parallel_in,
  output logic             shift_left_input,
  output logic             shift_right_input,
  input  logic [WIDTH-1:0] sr_q,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [1:0]        mode_q, mode_d;
  logic              last_bit;

  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    data_d  = data_q;
    mode_d  = MODE_HOLD;
    unique case (state_q)
      ST_IDLE: begin
        // in_ready is 1 throughout IDLE, so in_valid alone completes the handshake.
        if (in_valid) begin
          data_d  = in_data;
          dir_d   = in_msb_first;
          cnt_d   = '0;
          mode_d  = MODE_LOAD;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        mode_d  = dir_q ? MODE_SHL : MODE_SHR;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        mode_d = dir_q ? MODE_SHL : MODE_SHR;
        if (ser_ready) begin
          cnt_d = cnt_q + CntW'(1);
          if (last_bit) begin
            mode_d  = MODE_HOLD;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      data_q  <= '0;
      mode_q  <= MODE_HOLD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
    end
  end

  // The registered shift code is only forced to HOLD while the sink stalls, so the bit and the
  // register shift land on the same edge. LOAD (11) can only come from mode_q, i.e. only in LOAD.
  always_comb begin
    {s1, s0} = mode_q;
    if (state_q == ST_SHIFT && !ser_ready) begin
      {s1, s0} = MODE_HOLD;
    end
  end

  assign in_ready          = (state_q == ST_IDLE);
  assign ser_valid         = (state_q == ST_SHIFT);
  assign done              = (state_q == ST_DONE);
  assign ser_out           = dir_q ? sr_q[WIDTH-1] : sr_q[0];
  assign parallel_in       = data_q;
  assign shift_left_input  = FILL;
  assign shift_right_input = FILL;

endmodule

// File: tb/tb_sr_shift_ctrl.sv
module tb_sr_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_msb_first;
  logic       s1, s0;
  logic [7:0] parallel_in;
  logic       shift_left_input, shift_right_input;
  logic [7:0] sr_out;
  logic       ser_out, ser_valid, ser_ready, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sr_shift_ctrl #(.WIDTH(8), .FILL(1'b0)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_msb_first      (in_msb_first),
    .s1                (s1),
    .s0                (s0),
    .parallel_in       (parallel_in),
    .shift_left_input  (shift_left_input),
    .shift_right_input (shift_right_input),
    .sr_q              (sr_out),
    .ser_out           (ser_out),
    .ser_valid         (ser_valid),
    .ser_ready         (ser_ready),
    .done              (done)
  );

  eightbitsr u_sr (
    .clk               (clk),
    .s1                (s1),
    .s0                (s0),
    .parallel_in       (parallel_in),
    .shift_left_input  (shift_left_input),
    .shift_right_input (shift_right_input),
    .out               (sr_out)
  );

  // Expected serial stream, first bit in bit 7.
  function automatic logic [7:0] stream_of(input logic [7:0] w, input logic msb_first);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = msb_first ? w[7-i] : w[i];
    return r;
  endfunction

  // Offers one word and collects the serial stream. Cycle numbers: acc_c is the cycle after the
  // accept edge (LOAD); protocol violations observed along the way are counted in bad.
  task automatic run_word(input logic [7:0] data, input logic dir, input int stall_after,
                          input int stall_len, input bit rnd_ready, input bit hold_valid,
                          input logic [7:0] next_data, output logic [7:0] got,
                          output int nbits, output int acc_c, output int first_c,
                          output int done_c, output int stalls, output int bad,
                          output bit timeout);
    int n, stall_left, guard, c;
    logic ready, prev_ser;
    bit prev_stall;
    got = '0; n = 0; bad = 0; timeout = 0; stalls = 0;
    acc_c = -1; first_c = -1; done_c = -1; stall_left = stall_len;
    prev_stall = 0; prev_ser = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = data; in_msb_first = dir; ser_ready = 1'b0;
    #1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk); #1; guard++;
    end
    if (!in_ready) begin
      timeout = 1; nbits = 0; in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc_c = cyc;
    if (hold_valid) begin
      in_data = next_data;
    end else begin
      in_valid = 1'b0;
      in_data = ~data;
      in_msb_first = ~dir;
    end
    guard = 0;
    while (guard < 200) begin
      @(negedge clk);
      if (rnd_ready) begin
        ready = ($urandom_range(0, 3) != 0);
      end else if (stall_after >= 0 && n == stall_after && stall_left > 0) begin
        ready = 1'b0;
        stall_left--;
      end else begin
        ready = 1'b1;
      end
      ser_ready = ready;
      #1;
      c = cyc;
      if (c == acc_c) begin
        if ({s1, s0} !== 2'b11 || ser_valid !== 1'b0) bad++;
      end else if ({s1, s0} === 2'b11) begin
        bad++;
      end
      if (in_ready !== 1'b0) bad++;
      if (ser_valid === 1'b1) begin
        if ({s1, s0} !== (ready ? (dir ? 2'b10 : 2'b01) : 2'b00)) bad++;
        if (prev_stall && ser_out !== prev_ser) bad++;
        if (ready) begin
          if (first_c < 0) first_c = c;
          if (n < 8) got[7-n] = ser_out;
          n++;
        end else begin
          stalls++;
        end
        prev_stall = !ready;
        prev_ser = ser_out;
      end else begin
        prev_stall = 0;
      end
      if (done === 1'b1) begin
        done_c = c;
        if (ser_valid !== 1'b0 || {s1, s0} !== 2'b00) bad++;
        break;
      end
      guard++;
    end
    if (done_c < 0) timeout = 1;
    nbits = n;
    ser_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_msb_first = 1'b0; ser_ready = 1'b0;
    #3;
    checks++;
    if ({s1, s0, in_ready, ser_valid, done} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_por: got s=%b ready=%b valid=%b done=%b want s=00 ready=1 valid=0 done=0",
               {s1, s0}, in_ready, ser_valid, done);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #2; rst_n = 1'b0; #1;
    checks++;
    if ({s1, s0, in_ready, ser_valid, done} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_idle: got s=%b ready=%b valid=%b done=%b want 00 1 0 0",
               {s1, s0}, in_ready, ser_valid, done);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_msb_first();
    logic [7:0] got; int nb, a, f, d, st, bad; bit to;
    run_word(8'h1E, 1'b1, -1, 0, 0, 0, 8'h00, got, nb, a, f, d, st, bad, to);
    checks++;
    if (to || got !== stream_of(8'h1E, 1'b1) || nb != 8) begin
      errors++;
      $display("FAIL msb_stream: got %b (%0d bits, to=%0b) want %b", got, nb, to,
               stream_of(8'h1E, 1'b1));
    end
    checks++;
    if (f != a + 1 || d != a + 9) begin
      errors++;
      $display("FAIL msb_latency: first=+%0d done=+%0d want +1 +9", f - a, d - a);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL msb_protocol: got %0d violations want 0", bad);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] got; int nb, a, f, d, st, bad; bit to;
    run_word(8'h1E, 1'b0, -1, 0, 0, 0, 8'h00, got, nb, a, f, d, st, bad, to);
    checks++;
    if (to || got !== 8'b0111_1000) begin
      errors++;
      $display("FAIL lsb_stream: got %b want 01111000", got);
    end
    checks++;
    if (bad != 0 || d != a + 9) begin
      errors++;
      $display("FAIL lsb_protocol: got %0d violations done=+%0d want 0 +9", bad, d - a);
    end
    checks++;
    if (sr_out !== 8'h00) begin
      errors++;
      $display("FAIL lsb_final_reg: got %h want 00", sr_out);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] got; int nb, a, f, d, st, bad; bit to;
    run_word(8'hA5, 1'b1, 2, 3, 0, 0, 8'h00, got, nb, a, f, d, st, bad, to);
    checks++;
    if (to || got !== 8'b1010_0101) begin
      errors++;
      $display("FAIL bp_stream: got %b want 10100101", got);
    end
    checks++;
    if (d != a + 12 || st != 3) begin
      errors++;
      $display("FAIL bp_done_delay: done=+%0d stalls=%0d want +12 3", d - a, st);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold_frozen: got %0d violations want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] g1, g2; int n1, a1, f1, d1, s1c, b1, n2, a2, f2, d2, s2c, b2; bit t1, t2;
    run_word(8'hFF, 1'b1, -1, 0, 0, 1, 8'h00, g1, n1, a1, f1, d1, s1c, b1, t1);
    run_word(8'h00, 1'b1, -1, 0, 0, 0, 8'h00, g2, n2, a2, f2, d2, s2c, b2, t2);
    checks++;
    if (t1 || t2 || g1 !== 8'hFF || g2 !== 8'h00) begin
      errors++;
      $display("FAIL b2b_streams: got %h %h want ff 00", g1, g2);
    end
    checks++;
    if (a2 != d1 + 2) begin
      errors++;
      $display("FAIL b2b_accept: second accept %0d cycles after done want 2", a2 - d1);
    end
    checks++;
    if (b1 != 0 || b2 != 0) begin
      errors++;
      $display("FAIL b2b_busy_ready: got %0d/%0d violations want 0", b1, b2);
    end
  endtask

  task automatic test_reset_mid();
    int n, guard; bit saw_done;
    logic [7:0] got; int nb, a, f, d, st, bad; bit to;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hC3; in_msb_first = 1'b1; ser_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    n = 0; guard = 0;
    while (n < 4 && guard < 50) begin
      @(negedge clk); #1;
      if (ser_valid === 1'b1) n++;
      guard++;
    end
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    checks++;
    if (n != 4 || {s1, s0, in_ready, ser_valid, done} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_mid: bits=%0d s=%b ready=%b valid=%b done=%b want 4 00 1 0 0",
               n, {s1, s0}, in_ready, ser_valid, done);
    end
    saw_done = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (done !== 1'b0) saw_done = 1;
    end
    rst_n = 1'b1; ser_ready = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      if (done !== 1'b0) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL reset_no_done: got a done pulse want none");
    end
    checks++;
    if (sr_out !== 8'h30) begin
      errors++;
      $display("FAIL reset_reg_held: got %h want 30", sr_out);
    end
    run_word(8'h3C, 1'b1, -1, 0, 0, 0, 8'h00, got, nb, a, f, d, st, bad, to);
    checks++;
    if (to || got !== 8'b0011_1100 || bad != 0 || d != a + 9) begin
      errors++;
      $display("FAIL reset_recover: got %b bad=%0d done=+%0d want 00111100 0 +9",
               got, bad, d - a);
    end
  endtask

  task automatic test_random();
    logic [7:0] w, got; logic dir; int nb, a, f, d, st, bad; bit to;
    for (int k = 0; k < 24; k++) begin
      w = 8'($urandom);
      dir = 1'($urandom_range(0, 1));
      run_word(w, dir, -1, 0, 1, 0, 8'h00, got, nb, a, f, d, st, bad, to);
      checks++;
      if (to || got !== stream_of(w, dir) || nb != 8) begin
        errors++;
        $display("FAIL rnd_stream[%0d]: word %h dir %0b got %b want %b", k, w, dir, got,
                 stream_of(w, dir));
      end
      checks++;
      if (bad != 0 || d != a + 9 + st || sr_out !== 8'h00) begin
        errors++;
        $display("FAIL rnd_timing[%0d]: bad=%0d done=+%0d stalls=%0d reg=%h want 0 +%0d 00",
                 k, bad, d - a, st, sr_out, 9 + st);
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
